// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues one ROM read per cycle from the PC and queues the returned words with their PCs.
// The queued words go to the decoder over a valid/ready handshake. pc_stall back-pressures the PC; flush discards all fetched and in-flight words.
module instruction_fetch #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 16,
  parameter int unsigned DW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] pc_in,
  input  logic          flush,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] instr_pc,
  output logic          instr_valid,
  input  logic          out_ready,
  output logic          pc_stall
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;

  logic [CW-1:0] r_count;
  logic          r_p;
  logic [AW-1:0] r_p_pc;
  ptr_t          r_rd;
  ptr_t          r_wr;
  logic [DW-1:0] r_data [DEPTH];
  logic [AW-1:0] r_pc   [DEPTH];

  logic          w_pop;
  logic          w_push;
  logic          w_issue;
  logic [CW:0]   w_occ;
  logic [CW:0]   w_limit;

  function automatic ptr_t next_ptr(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign rom_addr    = pc_in;
  assign instr_valid = (r_count != '0);
  assign instr       = r_data[r_rd];
  assign instr_pc    = r_pc[r_rd];
  assign w_pop       = instr_valid & out_ready;

  // Occupancy counts the word in flight; a pop this cycle frees a slot for it.
  assign w_occ    = {1'b0, r_count} + (CW + 1)'(r_p);
  assign w_limit  = (CW + 1)'(DEPTH) + (CW + 1)'(w_pop);
  assign pc_stall = reset & ~flush & (w_occ >= w_limit);
  assign w_issue  = reset & ~flush & ~pc_stall;
  assign w_push   = reset & ~flush & r_p;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
      r_p     <= 1'b0;
      r_p_pc  <= '0;
      r_rd    <= '0;
      r_wr    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_pc[i]   <= '0;
      end
    end else if (flush) begin
      r_count <= '0;
      r_p     <= 1'b0;
      r_rd    <= '0;
      r_wr    <= '0;
    end else begin
      r_p    <= w_issue;
      r_p_pc <= pc_in;
      if (w_push) begin
        r_data[r_wr] <= rom_data;
        r_pc[r_wr]   <= r_p_pc;
        r_wr         <= next_ptr(r_wr);
      end
      if (w_pop) begin
        r_rd <= next_ptr(r_rd);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
